minilogix_cfg_loader: RTL and testbench
=======================================

MINILOGIX_CFG_LOADER -- requirements
Module: minilogix_cfg_loader

Upstream stage: turns a byte stream into the serial configuration protocol (load_en / load_clk / load_dat) consumed by the programmable logic block.

Interface
REQ-001 SHALL have parameter CFG_BITS, default 64: total configuration bits per frame, range 1..4096.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per load_clk phase (low or high), range 1..255.
REQ-003 SHALL have clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have rst_n, input, 1: reset is synchronous and active-low.
REQ-005 SHALL have i_start, input, 1: begin a frame; honoured only in IDLE.
REQ-006 SHALL have i_abort, input, 1: terminate the current frame.
REQ-007 SHALL have i_byte, input, 8: configuration data, MSB sent first.
REQ-008 SHALL have i_byte_valid, input, 1: i_byte holds valid data.
REQ-009 SHALL have o_byte_ready, output, 1: loader accepts i_byte this cycle.
REQ-010 SHALL have o_load_en, output, 1: frame enable to the logic block.
REQ-011 SHALL have o_load_clk, output, 1: serial clock; the consumer samples o_load_dat on its rising edge.
REQ-012 SHALL have o_load_dat, output, 1: serial data.
REQ-013 SHALL have o_busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have o_done, output, 1: one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement the states IDLE, WAIT_BYTE, SHIFT_LO, SHIFT_HI, TRAIL and DONE.
REQ-016 IDLE: i_start=1 SHALL move the block to WAIT_BYTE on the next cycle; o_load_en SHALL rise in that same cycle.
REQ-017 WAIT_BYTE: o_byte_ready SHALL be 1 (registered), and the block SHALL hold o_load_clk=0 indefinitely until a byte arrives. No underrun timeout applies.
REQ-018 A byte SHALL be accepted only when i_byte_valid and o_byte_ready are both 1; the transfer latches the byte into the shift register and moves the block to SHIFT_LO.
REQ-019 o_byte_ready SHALL be 0 in every state except WAIT_BYTE.
REQ-020 SHIFT_LO: o_load_dat SHALL show the current bit (MSB first), with o_load_clk=0 for exactly CLK_DIV cycles, then the block moves to SHIFT_HI.
REQ-021 SHIFT_HI: o_load_clk SHALL be 1 for exactly CLK_DIV cycles, and o_load_dat SHALL stay stable throughout.
REQ-022 At the end of SHIFT_HI, the 12-bit sent-bit counter SHALL increment, with the following next state:
  - TRAIL if the count has reached CFG_BITS;
  - WAIT_BYTE if 8 bits of the current byte have been sent;
  - SHIFT_LO otherwise.
REQ-023 When CFG_BITS is not a multiple of 8, the final byte SHALL be partial: only its upper (CFG_BITS mod 8) bits are sent and the rest are discarded.
REQ-024 TRAIL: the block SHALL hold o_load_en=1 and o_load_clk=0 for CLK_DIV cycles, then move to DONE.
REQ-025 DONE: o_load_en SHALL be 0 and o_done SHALL be 1 for exactly one cycle, then the block returns to IDLE.
REQ-026 i_abort in any state other than IDLE SHALL move the block to IDLE on the next cycle and clear o_load_en, o_load_clk, o_load_dat and the bit counter; no o_done pulse is generated.
REQ-027 i_abort SHALL take priority over every other transition, including a simultaneous valid/ready handshake; that byte is dropped.
REQ-028 i_start SHALL be ignored while o_busy=1; i_start and i_abort together in IDLE SHALL leave the block in IDLE.
REQ-029 o_load_clk, o_load_dat and o_load_en SHALL be driven directly from flops (glitch-free).
REQ-030 A full frame with no stalls SHALL last 1 + ceil(CFG_BITS/8)*2 + CFG_BITS*2*CLK_DIV + CLK_DIV + 1 cycles from i_start to o_done inclusive. Each byte costs one cycle in WAIT_BYTE and one transfer cycle.

Reset
REQ-031 With rst_n=0 at a clk edge, the block SHALL enter IDLE, and the outputs SHALL be o_load_en=0, o_load_clk=0, o_load_dat=0, o_byte_ready=0, o_busy=0, o_done=0.
REQ-032 Reset mid-frame SHALL behave like an abort; after rst_n returns high, a new i_start SHALL be required.

Verification
REQ-033 Run with CLK_DIV=2, CFG_BITS=16, bytes 0xA5 then 0x3C, no stalls. Required response:
  - serial bits 1010_0101_0011_1100 sampled at the o_load_clk rising edges;
  - exactly 16 o_load_clk pulses, each 2 cycles high;
  - o_done one cycle after TRAIL.
REQ-034 Run with CLK_DIV=1, CFG_BITS=12, bytes 0xF0 and 0xFF. Required response: 12 pulses carrying bits 1111_0000_1111; the low nibble of the second byte is never output.
REQ-035 Stall i_byte_valid low for 20 cycles between bytes. Required response: o_load_clk=0, o_load_en=1 and o_byte_ready=1 for the whole stall; the serial data is unchanged once the stream resumes.
REQ-036 Assert i_abort during SHIFT_HI of bit 5. Required response: next cycle o_load_en=0, o_load_clk=0, o_busy=0, and no o_done. A following i_start sends a complete frame from bit 0.
REQ-037 Pulse i_start again while busy. Required response: no effect on the frame and the pulse count is unchanged.
REQ-038 Drive rst_n=0 mid-byte. Required response: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/minilogix_cfg_loader.sv
// -----------------------------------------------------------------------------
// minilogix_cfg_loader
//   Converts a byte stream into the serial configuration protocol
//   (load_en / load_clk / load_dat) of the programmable logic block.
//   Bytes are shifted out MSB first. Each bit is held with load_clk low for
//   CLK_DIV cycles, then with load_clk high for CLK_DIV cycles. The consumer
//   samples load_dat on the rising edge of load_clk.
//
// Parameters
//   CFG_BITS  configuration bits per frame (1..4096)
//   CLK_DIV   clk cycles per load_clk phase (1..255)
//
// Ports
//   clk, rst_n     clock and synchronous active-low reset
//   i_start        start a frame (accepted only when idle)
//   i_abort        terminate the current frame immediately
//   i_byte         configuration byte, MSB first
//   i_byte_valid   i_byte is valid
//   o_byte_ready   loader takes i_byte this cycle (valid & ready)
//   o_load_en      frame enable
//   o_load_clk     serial clock
//   o_load_dat     serial data
//   o_busy         not idle
//   o_done         one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module minilogix_cfg_loader #(
    parameter int CFG_BITS = 64,
    parameter int CLK_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    output logic       o_load_en,
    output logic       o_load_clk,
    output logic       o_load_dat,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_TRAIL,
        S_DONE
    } state_e;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    // The count is compared one short of CFG_BITS, so a 12-bit counter
    // still covers CFG_BITS = 4096.
    localparam logic [12:0] BITS_LAST = 13'(CFG_BITS - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;

    logic ready_q, ready_d;
    logic en_q, en_d;
    logic clk_q, clk_d;
    logic dat_q, dat_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic phase_end;
    logic accept;
    logic last_bit;

    assign phase_end = (div_q == DIV_LAST);
    assign accept    = ready_q & i_byte_valid;
    assign last_bit  = ({1'b0, cnt_q} == BITS_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;

        if (state_q != S_IDLE && i_abort) begin
            // Abort beats everything, including a handshake in this cycle.
            state_d = S_IDLE;
            div_d   = '0;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        state_d = S_WAIT_BYTE;
                        div_d   = '0;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end
                S_WAIT_BYTE: begin
                    if (accept) begin
                        sh_d    = i_byte;
                        bit_d   = '0;
                        div_d   = '0;
                        state_d = S_SHIFT_LO;
                    end
                end
                S_SHIFT_LO: begin
                    if (phase_end) begin
                        div_d   = '0;
                        state_d = S_SHIFT_HI;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (phase_end) begin
                        div_d = '0;
                        cnt_d = cnt_q + 12'd1;
                        bit_d = bit_q + 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                        // Frame end wins over byte end: a partial last byte
                        // simply drops its unsent low bits.
                        if (last_bit)
                            state_d = S_TRAIL;
                        else if (bit_q == 3'd7)
                            state_d = S_WAIT_BYTE;
                        else
                            state_d = S_SHIFT_LO;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                S_TRAIL: begin
                    if (phase_end) begin
                        div_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with
        // state_q and come straight from flops.
        en_d   = (state_d == S_WAIT_BYTE) || (state_d == S_SHIFT_LO) ||
                 (state_d == S_SHIFT_HI)  || (state_d == S_TRAIL);
        clk_d  = (state_d == S_SHIFT_HI);
        dat_d  = ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) ? sh_d[7] : 1'b0;
        // Ready rises on the second WAIT_BYTE cycle, so every byte costs one
        // wait cycle plus one transfer cycle.
        ready_d = (state_q == S_WAIT_BYTE) && (state_d == S_WAIT_BYTE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            clk_q   <= 1'b0;
            dat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_byte_ready = ready_q;
    assign o_load_en    = en_q;
    assign o_load_clk   = clk_q;
    assign o_load_dat   = dat_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_minilogix_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_minilogix_cfg_loader
//   Two loaders: instance 0 (CLK_DIV=2, CFG_BITS=16) and instance 1
//   (CLK_DIV=1, CFG_BITS=12). A table of frames is driven through them.
//   Hand-written sequences cover abort, reset and start/abort corner cases.
// -----------------------------------------------------------------------------
module tb_minilogix_cfg_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st[2], ab[2], vl[2];
    logic [7:0] by[2];
    logic       rdy_o[2], en_o[2], lclk_o[2], dat_o[2], busy_o[2], done_o[2];

    minilogix_cfg_loader #(.CFG_BITS(16), .CLK_DIV(2)) u0 (
        .clk(clk), .rst_n(rst_n), .i_start(st[0]), .i_abort(ab[0]),
        .i_byte(by[0]), .i_byte_valid(vl[0]), .o_byte_ready(rdy_o[0]),
        .o_load_en(en_o[0]), .o_load_clk(lclk_o[0]), .o_load_dat(dat_o[0]),
        .o_busy(busy_o[0]), .o_done(done_o[0]));

    minilogix_cfg_loader #(.CFG_BITS(12), .CLK_DIV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_start(st[1]), .i_abort(ab[1]),
        .i_byte(by[1]), .i_byte_valid(vl[1]), .o_byte_ready(rdy_o[1]),
        .o_load_en(en_o[1]), .o_load_clk(lclk_o[1]), .o_load_dat(dat_o[1]),
        .o_busy(busy_o[1]), .o_done(done_o[1]));

    int errs = 0;
    int checks = 0;

    // feeder state
    logic [7:0] fbytes[2][2];
    int head[2], nbytes[2], stall_req[2], stall_left[2];
    logic armed[2], rdy_prev[2];
    // monitor state
    logic prev_clk[2], hi_dat[2];
    int hi_w[2], pulses[2], done_cnt[2], width_bad[2], dat_bad[2], stall_bad[2];
    logic [31:0] bits[2];

    typedef struct {
        int         inst;
        logic [7:0] b0;
        logic [7:0] b1;
        int         stall;
        int         restart;
        logic [31:0] bits;
        int         pulses;
        int         cycles;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs(input int i);
        return {en_o[i], lclk_o[i], dat_o[i], rdy_o[i], busy_o[i], done_o[i]};
    endfunction

    // One clock: waits for the falling edge, updates monitors and feeders.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rdy_prev[i] && vl[i]) begin
                head[i]++;
                if (head[i] == 1 && stall_req[i] > 0) armed[i] = 1'b1;
            end
            if (lclk_o[i] && !prev_clk[i]) begin
                pulses[i]++;
                bits[i]   = {bits[i][30:0], dat_o[i]};
                hi_w[i]   = 1;
                hi_dat[i] = dat_o[i];
            end else if (lclk_o[i] && prev_clk[i]) begin
                hi_w[i]++;
                if (dat_o[i] !== hi_dat[i]) dat_bad[i]++;
            end else if (!lclk_o[i] && prev_clk[i]) begin
                if (hi_w[i] != ((i == 0) ? 2 : 1)) width_bad[i]++;
            end
            prev_clk[i] = lclk_o[i];
            if (done_o[i]) done_cnt[i]++;
            if (armed[i] && rdy_o[i]) begin
                stall_left[i] = stall_req[i];
                armed[i] = 1'b0;
            end
            if (stall_left[i] > 0) begin
                if (!(rdy_o[i] && !lclk_o[i] && en_o[i])) stall_bad[i]++;
                stall_left[i]--;
                vl[i] = 1'b0;
            end else begin
                vl[i] = (head[i] < nbytes[i]);
                by[i] = fbytes[i][(head[i] < 2) ? head[i] : 1];
            end
            rdy_prev[i] = rdy_o[i];
        end
    endtask

    task automatic start_frame(input int i, input logic [7:0] b0, input logic [7:0] b1,
                               input int stall);
        fbytes[i][0] = b0; fbytes[i][1] = b1;
        head[i] = 0; nbytes[i] = 2; stall_req[i] = stall; stall_left[i] = 0;
        armed[i] = 1'b0;
        hi_w[i] = 0; pulses[i] = 0; done_cnt[i] = 0; bits[i] = '0;
        width_bad[i] = 0; dat_bad[i] = 0; stall_bad[i] = 0;
        st[i] = 1'b1;
        tick();
        st[i] = 1'b0;
    endtask

    task automatic run_frame(input int k);
        vec_t v;
        int i, n;
        v = vt[k];
        i = v.inst;
        start_frame(i, v.b0, v.b1, v.stall);
        // load_en rises on the first WAIT_BYTE cycle, ready not yet up
        chk($sformatf("v%0d_start", k), {28'd0, en_o[i], busy_o[i], rdy_o[i], lclk_o[i]}, 32'hC);
        n = 2;
        while (!done_o[i] && n < 400) begin
            tick();
            n++;
            if (n == v.restart) begin
                st[i] = 1'b1;
                tick();
                n++;
                st[i] = 1'b0;
            end
        end
        chk($sformatf("v%0d_cycles", k), n, v.cycles);
        repeat (3) tick();
        chk($sformatf("v%0d_bits", k), bits[i], v.bits);
        chk($sformatf("v%0d_pulses", k), pulses[i], v.pulses);
        chk($sformatf("v%0d_width", k), width_bad[i], 0);
        chk($sformatf("v%0d_datstable", k), dat_bad[i], 0);
        chk($sformatf("v%0d_stall", k), stall_bad[i], 0);
        chk($sformatf("v%0d_done", k), done_cnt[i], 1);
        chk($sformatf("v%0d_idle", k), outs(i), 6'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; ab[i] = 0; vl[i] = 0; by[i] = 0;
            head[i] = 0; nbytes[i] = 0; stall_req[i] = 0; stall_left[i] = 0;
            armed[i] = 0; rdy_prev[i] = 0; prev_clk[i] = 0; hi_dat[i] = 0;
            hi_w[i] = 0; pulses[i] = 0; done_cnt[i] = 0; bits[i] = 0;
            width_bad[i] = 0; dat_bad[i] = 0; stall_bad[i] = 0;
            fbytes[i][0] = 0; fbytes[i][1] = 0;
        end
        //         inst b0     b1     stall rst bits        pulses cycles
        vt[0] = '{0, 8'hA5, 8'h3C, 0,  0,  32'hA53C, 16, 72};
        vt[1] = '{1, 8'hF0, 8'hFF, 0,  0,  32'h0F0F, 12, 31};
        vt[2] = '{0, 8'hA5, 8'h3C, 20, 0,  32'hA53C, 16, 92};
        vt[3] = '{0, 8'h00, 8'hFF, 0,  0,  32'h00FF, 16, 72};
        vt[4] = '{1, 8'h5A, 8'hC3, 0,  0,  32'h05AC, 12, 31};
        vt[5] = '{1, 8'h81, 8'h7E, 20, 0,  32'h0817, 12, 51};
        vt[6] = '{0, 8'hA5, 8'h3C, 0,  30, 32'hA53C, 16, 72};
        vt[7] = '{1, 8'h3C, 8'h96, 0,  5,  32'h03C9, 12, 31};

        repeat (3) tick();
        chk("reset_u0", outs(0), 6'b0);
        chk("reset_u1", outs(1), 6'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_reset_idle", outs(0), 6'b0);

        for (int k = 0; k < 8; k++) run_frame(k);

        // abort during SHIFT_HI of bit 5
        start_frame(0, 8'hA5, 8'h3C, 0);
        for (int c = 0; c < 300 && !(pulses[0] == 6 && lclk_o[0]); c++) tick();
        chk("abort_reach_bit5", pulses[0], 6);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("abort_outputs", {28'd0, en_o[0], lclk_o[0], dat_o[0], busy_o[0]}, 32'h0);
        repeat (5) tick();
        chk("abort_no_done", done_cnt[0], 0);
        chk("abort_no_pulses", pulses[0], 6);
        run_frame(0);

        // abort together with a valid/ready handshake drops the byte
        start_frame(1, 8'hFF, 8'hFF, 0);
        for (int c = 0; c < 50 && !(rdy_o[1] && vl[1]); c++) tick();
        chk("hs_ready_seen", {31'd0, rdy_o[1] & vl[1]}, 1);
        ab[1] = 1'b1;
        tick();
        ab[1] = 1'b0;
        chk("hs_abort_idle", {30'd0, en_o[1], busy_o[1]}, 0);
        repeat (5) tick();
        chk("hs_abort_no_pulse", pulses[1], 0);
        chk("hs_abort_no_done", done_cnt[1], 0);

        // start and abort together in IDLE stay idle
        st[1] = 1'b1; ab[1] = 1'b1;
        tick();
        st[1] = 1'b0; ab[1] = 1'b0;
        chk("start_abort_idle", outs(1), 6'b0);
        repeat (3) tick();
        chk("start_abort_stays", outs(1), 6'b0);

        // reset mid-byte
        start_frame(0, 8'hA5, 8'h3C, 0);
        for (int c = 0; c < 300 && pulses[0] < 3; c++) tick();
        chk("rst_reach", pulses[0], 3);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_outputs", outs(0), 6'b0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_needs_start", outs(0), 6'b0);
        run_frame(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
